mem_lsu: RTL
============

MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 Parameter: DBUS_TIMEOUT, default 255; max cycles in WAIT before bus-error abort.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 ex_wd  in  5  destination register address from EX/MEM.
REQ-005 ex_wreg  in  1  register write enable from EX/MEM.
REQ-006 ex_wdata  in  32  ALU result; for memory ops, the effective address.
REQ-007 ex_sdata  in  32  store data (rt value).
REQ-008 ex_aluop  in  8  operation code.
REQ-009 ex_pc  in  32  instruction PC.
REQ-010 dbus_req / dbus_we  out  1 / 1  data-bus request / write strobe.
REQ-011 dbus_addr  out  32  word-aligned address, {ex_wdata[31:2],2'b00}.
REQ-012 dbus_be / dbus_wdata  out  4 / 32  byte enables / lane-replicated store data.
REQ-013 dbus_rdata / dbus_ack  in  32 / 1  read data / transfer complete.
REQ-014 mem_wd, mem_wreg, mem_wdata, mem_pc, mem_aluop  out  5,1,32,32,8  to MEM/WB register.
REQ-015 stallreq_mem  out  1  pipeline stall request to stall controller.
REQ-016 mem_excp  out  2  00 none, 01 load misaligned, 10 store misaligned, 11 bus timeout.

Function
REQ-017 Non-memory aluop: all mem_* outputs equal ex_* inputs combinationally; dbus_req=0; stallreq_mem=0.
REQ-018 Byte lane k = address[1:0]; lane 0 = bits 7:0 (little-endian).
REQ-019 LB/LBU: be=1<<k; LH/LHU: be=3<<k; LW: be=4'hF; stores identical with dbus_we=1.
REQ-020 SB replicates sdata[7:0] to all 4 lanes; SH replicates sdata[15:0] to both halves; SW passes sdata.
REQ-021 LB/LH sign-extend selected lane; LBU/LHU zero-extend; LW passes word.
REQ-022 Misaligned (halfword with addr[0]=1, word with addr[1:0]!=0): no bus request, mem_wreg=0, mem_excp set, no stall.
REQ-023 FSM states IDLE, WAIT, DONE.
REQ-024 IDLE, aligned memory op: dbus_req=1; if dbus_ack same cycle, complete with zero wait (load data from dbus_rdata), stay IDLE; else stallreq_mem=1, go WAIT.
REQ-025 WAIT: dbus_req=1, stallreq_mem=1, addr/be/wdata held from inputs (upstream stalled); on dbus_ack latch dbus_rdata into rdata_q, go DONE.
REQ-026 DONE: dbus_req=0, stallreq_mem=0, load result from rdata_q, go IDLE next cycle; exactly one bus transfer per instruction.
REQ-027 WAIT timeout counter (8-bit) increments per WAIT cycle; reaching DBUS_TIMEOUT goes DONE with mem_wreg=0, mem_excp=11.
REQ-028 Stores never write a register: mem_wreg forced 0 for SB/SH/SW.
REQ-029 dbus_ack outside WAIT or an IDLE request cycle is ignored.

Reset
REQ-030 rst=1 at a clock edge: state=IDLE, rdata_q=0, timeout counter=0; dbus_req=0 from next cycle even mid-WAIT.
REQ-031 During reset all registered state is cleared; combinational outputs follow REQ-017 with state IDLE.

Structure
REQ-032 Aluop codes (LB, LBU, LH, LHU, LW, SB, SH, SW, NOP) and the mem_excp encoding belong in the shared defines package.
REQ-033 One sub-module is natural: lsu_align (combinational byte-enable/store-replicate/load-extract-extend).

Verification
REQ-034 LB addr 0x1003, rdata 0x80FF_0000, zero-wait ack -> be=4'b1000, mem_wdata=0xFFFF_FF80, stallreq_mem never 1.
REQ-035 LHU addr 0x2002, ack after 3 cycles, rdata 0x8001_1234 -> stallreq_mem high 3 cycles plus ack cycle, DONE gives mem_wdata=0x0000_8001.
REQ-036 SB addr 0x3001, sdata 0x0000_00AB -> dbus_we=1, be=4'b0010, wdata=0xABAB_ABAB, mem_wreg=0.
REQ-037 LW addr 0x4002 -> dbus_req=0, mem_excp=01, mem_wreg=0, no stall.
REQ-038 LW with no ack, DBUS_TIMEOUT=4 -> 4 WAIT cycles, then DONE with mem_excp=11, mem_wreg=0, IDLE after.
REQ-039 rst asserted in 2nd WAIT cycle -> IDLE next cycle, dbus_req=0, stallreq_mem=0; late ack ignored.

Source files
------------

// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the load/store unit: aluop codes, exception codes,
// FSM states and the memory-op decode helper.
package mem_lsu_pkg;

    localparam logic [7:0] OP_NOP = 8'h00;
    localparam logic [7:0] OP_LB  = 8'h20;
    localparam logic [7:0] OP_LH  = 8'h21;
    localparam logic [7:0] OP_LW  = 8'h23;
    localparam logic [7:0] OP_LBU = 8'h24;
    localparam logic [7:0] OP_LHU = 8'h25;
    localparam logic [7:0] OP_SB  = 8'h28;
    localparam logic [7:0] OP_SH  = 8'h29;
    localparam logic [7:0] OP_SW  = 8'h2B;

    typedef enum logic [1:0] {
        EXCP_NONE      = 2'b00,
        EXCP_LOAD_MIS  = 2'b01,
        EXCP_STORE_MIS = 2'b10,
        EXCP_TIMEOUT   = 2'b11
    } excp_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_t;

    typedef struct packed {
        logic  is_mem;
        logic  is_load;
        logic  is_store;
        logic  sign_ext;
        size_t size;
    } memop_t;

    function automatic memop_t decode_op(input logic [7:0] op);
        memop_t d;
        d = '{is_mem: 1'b0, is_load: 1'b0, is_store: 1'b0, sign_ext: 1'b0, size: SZ_WORD};
        case (op)
            OP_LB:   d = '{1'b1, 1'b1, 1'b0, 1'b1, SZ_BYTE};
            OP_LBU:  d = '{1'b1, 1'b1, 1'b0, 1'b0, SZ_BYTE};
            OP_LH:   d = '{1'b1, 1'b1, 1'b0, 1'b1, SZ_HALF};
            OP_LHU:  d = '{1'b1, 1'b1, 1'b0, 1'b0, SZ_HALF};
            OP_LW:   d = '{1'b1, 1'b1, 1'b0, 1'b0, SZ_WORD};
            OP_SB:   d = '{1'b1, 1'b0, 1'b1, 1'b0, SZ_BYTE};
            OP_SH:   d = '{1'b1, 1'b0, 1'b1, 1'b0, SZ_HALF};
            OP_SW:   d = '{1'b1, 1'b0, 1'b1, 1'b0, SZ_WORD};
            default: ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// Combinational lane logic: byte enables, store-data replication and
// load-data extraction with sign/zero extension.
module mem_lsu_align
    import mem_lsu_pkg::*;
(
    input  size_t       size,
    input  logic        sign_ext,
    input  logic [1:0]  lane,
    input  logic [31:0] sdata,
    input  logic [31:0] rdata,
    output logic        misaligned,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] ldata
);

    logic [7:0]  rbyte [4];
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign rbyte[gi] = rdata[8*gi +: 8];
            // Every lane carries the store data so the slave can pick any byte lane.
            assign wdata[8*gi +: 8] = (size == SZ_BYTE) ? sdata[7:0] :
                                      (size == SZ_HALF) ? sdata[8*(gi%2) +: 8] :
                                                          sdata[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        case (size)
            SZ_BYTE: be = 4'b0001 << lane;
            SZ_HALF: be = 4'b0011 << lane;
            default: be = 4'b1111;
        endcase

        misaligned = ((size == SZ_HALF) && lane[0]) ||
                     ((size == SZ_WORD) && (lane != 2'b00));

        sel_byte = rbyte[lane];
        sel_half = lane[1] ? rdata[31:16] : rdata[15:0];

        case (size)
            SZ_BYTE: ldata = {{24{sign_ext & sel_byte[7]}}, sel_byte};
            SZ_HALF: ldata = {{16{sign_ext & sel_half[15]}}, sel_half};
            default: ldata = rdata;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: drives the data bus, stalls the pipeline while a
// transfer is outstanding, and aborts with a bus-timeout exception.
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int DBUS_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ex_wd,
    input  logic        ex_wreg,
    input  logic [31:0] ex_wdata,
    input  logic [31:0] ex_sdata,
    input  logic [7:0]  ex_aluop,
    input  logic [31:0] ex_pc,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [3:0]  dbus_be,
    output logic [31:0] dbus_wdata,
    input  logic [31:0] dbus_rdata,
    input  logic        dbus_ack,
    output logic [4:0]  mem_wd,
    output logic        mem_wreg,
    output logic [31:0] mem_wdata,
    output logic [31:0] mem_pc,
    output logic [7:0]  mem_aluop,
    output logic        stallreq_mem,
    output logic [1:0]  mem_excp
);

    localparam logic [7:0] TMO_LAST = 8'(DBUS_TIMEOUT - 1);

    state_t      state_reg, state_next;
    logic [31:0] rdata_reg, rdata_next;
    logic [7:0]  tmo_cnt_reg, tmo_cnt_next;
    logic        timed_out_reg, timed_out_next;

    memop_t      op;
    logic        misaligned;
    logic        mem_go;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] ldata;
    logic [31:0] align_rdata;

    assign op          = decode_op(ex_aluop);
    assign mem_go      = op.is_mem && !misaligned;
    // In DONE the bus data is gone; extract from the captured word instead.
    assign align_rdata = (state_reg == ST_DONE) ? rdata_reg : dbus_rdata;

    mem_lsu_align u_align (
        .size       (op.size),
        .sign_ext   (op.sign_ext),
        .lane       (ex_wdata[1:0]),
        .sdata      (ex_sdata),
        .rdata      (align_rdata),
        .misaligned (misaligned),
        .be         (be),
        .wdata      (wdata),
        .ldata      (ldata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            rdata_reg     <= '0;
            tmo_cnt_reg   <= '0;
            timed_out_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            rdata_reg     <= rdata_next;
            tmo_cnt_reg   <= tmo_cnt_next;
            timed_out_reg <= timed_out_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        rdata_next     = rdata_reg;
        tmo_cnt_next   = tmo_cnt_reg;
        timed_out_next = timed_out_reg;
        case (state_reg)
            ST_IDLE: begin
                if (mem_go && !dbus_ack) begin
                    state_next     = ST_WAIT;
                    tmo_cnt_next   = '0;
                    timed_out_next = 1'b0;
                end
            end
            ST_WAIT: begin
                if (dbus_ack) begin
                    rdata_next = dbus_rdata;
                    state_next = ST_DONE;
                end else if (tmo_cnt_reg == TMO_LAST) begin
                    timed_out_next = 1'b1;
                    state_next     = ST_DONE;
                end else begin
                    tmo_cnt_next = tmo_cnt_reg + 8'd1;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_wd       = ex_wd;
        mem_wreg     = ex_wreg;
        mem_wdata    = ex_wdata;
        mem_pc       = ex_pc;
        mem_aluop    = ex_aluop;
        mem_excp     = EXCP_NONE;
        dbus_req     = 1'b0;
        dbus_we      = 1'b0;
        dbus_addr    = {ex_wdata[31:2], 2'b00};
        dbus_be      = be;
        dbus_wdata   = wdata;
        stallreq_mem = 1'b0;
        if (!rst) begin
            case (state_reg)
                ST_IDLE: begin
                    if (op.is_mem && misaligned) begin
                        mem_wreg = 1'b0;
                        mem_excp = op.is_store ? EXCP_STORE_MIS : EXCP_LOAD_MIS;
                    end else if (op.is_mem) begin
                        dbus_req = 1'b1;
                        dbus_we  = op.is_store;
                        if (dbus_ack) begin
                            mem_wreg  = op.is_load & ex_wreg;
                            mem_wdata = op.is_load ? ldata : ex_wdata;
                        end else begin
                            mem_wreg     = 1'b0;
                            stallreq_mem = 1'b1;
                        end
                    end
                end
                ST_WAIT: begin
                    dbus_req     = 1'b1;
                    dbus_we      = op.is_store;
                    stallreq_mem = 1'b1;
                    mem_wreg     = 1'b0;
                end
                ST_DONE: begin
                    mem_wreg  = op.is_load & ex_wreg & !timed_out_reg;
                    mem_wdata = op.is_load ? ldata : ex_wdata;
                    mem_excp  = timed_out_reg ? EXCP_TIMEOUT : EXCP_NONE;
                end
                default: ;
            endcase
        end
    end

endmodule
